// File: rtl/prng_pkg.sv
// Shared types and constants for the PRNG arbiter: FSM encoding, LFSR taps,
// reset seed, requester count and the single-step LFSR function.
package prng_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StStep    = 2'd1,
        StDeliver = 2'd2
    } state_e;

    // Feedback taps: bits 0, 2, 3 and 4 feed the new MSB.
    localparam logic [7:0] LfsrTaps  = 8'h1D;
    localparam logic [7:0] ResetSeed = 8'h01;
    localparam int unsigned NumReq   = 2;

    // One LFSR shift; the all-zero lock-up state escapes to the reset seed.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        logic [7:0] n;
        if (s == 8'h00) begin
            n = ResetSeed;
        end else begin
            n = {^(s & LfsrTaps), s[7:1]};
        end
        return n;
    endfunction

endpackage

// File: rtl/prng_arbiter_if.sv
// Consumer-side bundle of the PRNG arbiter: seed-load handshake, per-requester
// request/ready/valid, shared data byte and status.
interface prng_arbiter_if;
    import prng_pkg::*;

    logic              seed_valid;
    logic [7:0]        seed;
    logic              seed_rdy;
    logic [NumReq-1:0] req;
    logic [NumReq-1:0] rdy;
    logic [NumReq-1:0] vld;
    logic [7:0]        data;
    logic              busy;
    logic [7:0]        lfsr_state;

    // Consumers / seed offerer.
    modport master (
        output seed_valid, seed, req, rdy,
        input  seed_rdy, vld, data, busy, lfsr_state
    );

    // The arbiter itself.
    modport slave (
        input  seed_valid, seed, req, rdy,
        output seed_rdy, vld, data, busy, lfsr_state
    );

endinterface

// File: rtl/lfsr8_core.sv
// 8-bit Fibonacci LFSR register with load and step enables and a zero guard.
// Load wins over step; a zero load value is replaced by the reset seed.
module lfsr8_core
    import prng_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step_en,
    input  logic       load_en,
    input  logic [7:0] load_val,
    output logic [7:0] state,
    output logic [7:0] state_next
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    assign state_next = lfsr_next(lfsr_q);
    assign state      = lfsr_q;

    // Next register value: load, step or hold.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_en) begin
            lfsr_d = (load_val == 8'h00) ? ResetSeed : load_val;
        end else if (step_en) begin
            lfsr_d = state_next;
        end
    end

    // LFSR register with synchronous reset to the reset seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= ResetSeed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/prng_arbiter.sv
// Round-robin controller sharing one LFSR between two requesters. Each grant
// shifts the LFSR STEPS times, then presents one byte on a valid/ready
// handshake. Optional build macro PRNG_FREERUN_EN also shifts the LFSR in
// every IDLE cycle that does not load a seed.
module prng_arbiter
    import prng_pkg::*;
#(
    parameter int unsigned STEPS = 8
) (
    input logic           clk,
    input logic           rst,
    prng_arbiter_if.slave bus
);

    localparam logic [3:0] StepsInit = 4'(STEPS - 1);

    state_e            state_q;
    state_e            state_d;
    logic [3:0]        cnt_q;
    logic [3:0]        cnt_d;
    logic              last_q;
    logic              last_d;
    logic              grant_q;
    logic              grant_d;
    logic [NumReq-1:0] vld_q;
    logic [NumReq-1:0] vld_d;
    logic [7:0]        data_q;
    logic [7:0]        data_d;

    logic       seed_take;
    logic       req_any;
    logic       pick;
    logic       start;
    logic       handshake;
    logic       step_done;
    logic       step_en;
    logic       load_en;
    logic       seed_rdy;
    logic       busy;
    logic [7:0] lfsr_state;
    logic [7:0] lfsr_state_next;

    lfsr8_core u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .step_en    (step_en),
        .load_en    (load_en),
        .load_val   (bus.seed),
        .state      (lfsr_state),
        .state_next (lfsr_state_next)
    );

    // Request decode: seed loading in IDLE beats a new grant.
    always_comb begin
        seed_take = (state_q == StIdle) && bus.seed_valid;
        req_any   = |bus.req;
        // On a tie the requester that did not complete last wins.
        pick      = (bus.req == 2'b11) ? ~last_q : bus.req[1];
        start     = (state_q == StIdle) && !seed_take && req_any;
        step_done = (state_q == StStep) && (cnt_q == 4'd0);
        handshake = (state_q == StDeliver) && bus.rdy[grant_q];
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start)     state_d = StStep;
            StStep:    if (step_done) state_d = StDeliver;
            StDeliver: if (handshake) state_d = StIdle;
            default:                  state_d = StIdle;
        endcase
    end

    // FSM outputs decoded straight from the state register.
    always_comb begin
        seed_rdy = (state_q == StIdle);
        busy     = (state_q != StIdle);
        load_en  = seed_take;
`ifdef PRNG_FREERUN_EN
        step_en  = (state_q == StStep) || ((state_q == StIdle) && !bus.seed_valid);
`else
        step_en  = (state_q == StStep);
`endif
    end

    // Datapath next values: step counter, grantee, round-robin pointer, output byte.
    always_comb begin
        cnt_d   = cnt_q;
        grant_d = grant_q;
        last_d  = last_q;
        vld_d   = vld_q;
        data_d  = data_q;
        if (start) begin
            grant_d = pick;
            cnt_d   = StepsInit;
        end
        if ((state_q == StStep) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (step_done) begin
            // Capture the value the final shift produces so data matches lfsr_state.
            vld_d  = grant_q ? 2'b10 : 2'b01;
            data_d = lfsr_state_next;
        end
        if (handshake) begin
            vld_d  = '0;
            last_d = grant_q;
        end
    end

    // Datapath registers; reset makes requester 0 win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 4'd0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            vld_q   <= '0;
            data_q  <= 8'h00;
        end else begin
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
        end
    end

    assign bus.seed_rdy   = seed_rdy;
    assign bus.busy       = busy;
    assign bus.vld        = vld_q;
    assign bus.data       = data_q;
    assign bus.lfsr_state = lfsr_state;

endmodule

// File: tb/tb_prng_arbiter.sv
// Self-checking bench for prng_arbiter: a reference LFSR model predicts each
// delivered byte into a scoreboard queue when a grant is requested; the queue
// is popped and compared when vld rises.
module tb_prng_arbiter;
    import prng_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    prng_arbiter_if bus ();
    prng_arbiter_if bus1 ();

    prng_arbiter #(.STEPS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    prng_arbiter #(.STEPS(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    typedef struct {
        int         g;
        logic [7:0] d;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model;
    int         n_checks = 0;
    int         n_fail   = 0;

    function automatic logic [7:0] step8(input logic [7:0] s);
        if (s == 8'h00) return 8'h01;
        return {s[0] ^ s[2] ^ s[3] ^ s[4], s[7:1]};
    endfunction

    task automatic predict(input int g, input int steps);
        exp_t e;
        for (int i = 0; i < steps; i++) model = step8(model);
        e.g = g;
        e.d = model;
        exp_q.push_back(e);
    endtask

    task automatic pop_exp(output exp_t e);
        if (exp_q.size() == 0) begin
            e.g = -1;
            e.d = 8'hxx;
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    // Waits (bounded) for any vld bit on the STEPS=8 instance; sampled on negedges.
    task automatic wait_vld(output int cycles, output bit timeout, output bit both);
        cycles  = 0;
        timeout = 1'b1;
        both    = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.vld === 2'b11) both = 1'b1;
            if (bus.vld !== 2'b00) begin
                cycles  = i;
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.seed_valid = 1'b0;  bus.seed = 8'h00;  bus.req = 2'b00;  bus.rdy = 2'b00;
        bus1.seed_valid = 1'b0; bus1.seed = 8'h00; bus1.req = 2'b00; bus1.rdy = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        model = 8'h01;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.vld !== 2'b00) begin n_fail++; $display("FAIL reset_vld: got %b want 00", bus.vld); end
        n_checks++; if (bus.data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", bus.data); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.seed_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_seed_rdy: got %b want 1", bus.seed_rdy); end
        n_checks++; if (bus.lfsr_state !== 8'h01) begin n_fail++; $display("FAIL reset_lfsr: got %h want 01", bus.lfsr_state); end
        n_checks++; if (bus1.lfsr_state !== 8'h01) begin n_fail++; $display("FAIL reset_lfsr1: got %h want 01", bus1.lfsr_state); end
`ifndef PRNG_FREERUN_EN
        @(negedge clk);
        n_checks++; if (bus.lfsr_state !== 8'h01) begin n_fail++; $display("FAIL idle_hold: got %h want 01", bus.lfsr_state); end
`endif
    endtask

    task automatic test_first_grant();
        int cyc; bit to; bit both; exp_t e;
        do_reset();
        bus.req = 2'b01; bus.rdy = 2'b01;
        predict(0, 8);
        wait_vld(cyc, to, both);
        pop_exp(e);
        n_checks++; if (to || cyc != 9) begin n_fail++; $display("FAIL first_latency: got %0d want 9 (timeout=%0b)", cyc, to); end
        n_checks++; if (bus.vld !== 2'b01) begin n_fail++; $display("FAIL first_vld: got %b want 01", bus.vld); end
        n_checks++; if (bus.data !== e.d) begin n_fail++; $display("FAIL first_data_model: got %h want %h", bus.data, e.d); end
        n_checks++; if (bus.data !== 8'h71) begin n_fail++; $display("FAIL first_data: got %h want 71", bus.data); end
        predict(0, 8);
        wait_vld(cyc, to, both);
        pop_exp(e);
        n_checks++; if (to || cyc != 10) begin n_fail++; $display("FAIL grant_period: got %0d want 10 (timeout=%0b)", cyc, to); end
        n_checks++; if (bus.data !== e.d) begin n_fail++; $display("FAIL second_data_model: got %h want %h", bus.data, e.d); end
        n_checks++; if (bus.data !== 8'hA4) begin n_fail++; $display("FAIL second_data: got %h want a4", bus.data); end
        bus.req = 2'b00;
        @(negedge clk);
        n_checks++; if (bus.vld !== 2'b00) begin n_fail++; $display("FAIL hs_vld_clear: got %b want 00", bus.vld); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL hs_busy: got %b want 0", bus.busy); end
        bus.rdy = 2'b00;
    endtask

    task automatic test_round_robin();
        int cyc; bit to; bit both; exp_t e; logic [1:0] want;
        do_reset();
        bus.req = 2'b11; bus.rdy = 2'b11;
        for (int k = 0; k < 4; k++) begin
            predict(k % 2, 8);
            wait_vld(cyc, to, both);
            pop_exp(e);
            want = (e.g == 1) ? 2'b10 : 2'b01;
            n_checks++; if (to || both) begin n_fail++; $display("FAIL rr_wait%0d: timeout=%0b both=%0b want 0 0", k, to, both); end
            n_checks++; if (bus.vld !== want) begin n_fail++; $display("FAIL rr_vld%0d: got %b want %b", k, bus.vld, want); end
            n_checks++; if (bus.data !== e.d) begin n_fail++; $display("FAIL rr_data%0d: got %h want %h", k, bus.data, e.d); end
        end
        bus.req = 2'b00;
        @(negedge clk);
        bus.rdy = 2'b00;
    endtask

    task automatic test_seed();
        int cyc; bit to; bit both; exp_t e; int hit;
        do_reset();
        bus.seed_valid = 1'b1; bus.seed = 8'h33;
        n_checks++; if (bus.seed_rdy !== 1'b1) begin n_fail++; $display("FAIL seed_rdy_idle: got %b want 1", bus.seed_rdy); end
        @(negedge clk);
        n_checks++; if (bus.lfsr_state !== 8'h33) begin n_fail++; $display("FAIL seed_load: got %h want 33", bus.lfsr_state); end
        bus.seed = 8'h00;
        @(negedge clk);
        n_checks++; if (bus.lfsr_state !== 8'h01) begin n_fail++; $display("FAIL seed_zero: got %h want 01", bus.lfsr_state); end
        // Seed and request in the same cycle: seed wins, no grant.
        bus.seed = 8'h5A; bus.req = 2'b01; bus.rdy = 2'b01;
        @(negedge clk);
        bus.seed_valid = 1'b0;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL seed_priority_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.lfsr_state !== 8'h5A) begin n_fail++; $display("FAIL seed_priority_lfsr: got %h want 5a", bus.lfsr_state); end
        model = 8'h5A;
        predict(0, 8);
        wait_vld(cyc, to, both);
        pop_exp(e);
        n_checks++; if (to || bus.data !== e.d) begin n_fail++; $display("FAIL seeded_data: got %h want %h (timeout=%0b)", bus.data, e.d, to); end
        bus.req = 2'b00;
        @(negedge clk);
        bus.rdy = 2'b00;
        // STEPS=1 instance: seed 10 then one grant.
        bus1.seed_valid = 1'b1; bus1.seed = 8'h10;
        @(negedge clk);
        bus1.seed_valid = 1'b0;
        n_checks++; if (bus1.lfsr_state !== 8'h10) begin n_fail++; $display("FAIL seed1_load: got %h want 10", bus1.lfsr_state); end
        bus1.req = 2'b01; bus1.rdy = 2'b01;
        hit = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus1.vld !== 2'b00) begin hit = i; break; end
        end
        n_checks++; if (hit != 2) begin n_fail++; $display("FAIL steps1_latency: got %0d want 2", hit); end
        n_checks++; if (bus1.data !== step8(8'h10)) begin n_fail++; $display("FAIL steps1_data_model: got %h want %h", bus1.data, step8(8'h10)); end
        n_checks++; if (bus1.data !== 8'h88) begin n_fail++; $display("FAIL steps1_data: got %h want 88", bus1.data); end
        bus1.req = 2'b00;
        @(negedge clk);
        bus1.rdy = 2'b00;
    endtask

    task automatic test_backpressure();
        int cyc; bit to; bit both; exp_t e;
        do_reset();
        bus.req = 2'b01; bus.rdy = 2'b00;
        predict(0, 8);
        wait_vld(cyc, to, both);
        pop_exp(e);
        n_checks++; if (to || bus.data !== e.d) begin n_fail++; $display("FAIL bp_data: got %h want %h (timeout=%0b)", bus.data, e.d, to); end
        // Drop the request, offer a seed, and raise the other requester's ready.
        bus.req = 2'b00; bus.rdy = 2'b10; bus.seed_valid = 1'b1; bus.seed = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (bus.seed_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_seed_rdy%0d: got %b want 0", k, bus.seed_rdy); end
            @(negedge clk);
            n_checks++; if (bus.vld !== 2'b01) begin n_fail++; $display("FAIL bp_vld%0d: got %b want 01", k, bus.vld); end
            n_checks++; if (bus.data !== e.d) begin n_fail++; $display("FAIL bp_hold%0d: got %h want %h", k, bus.data, e.d); end
            n_checks++; if (bus.lfsr_state !== e.d) begin n_fail++; $display("FAIL bp_lfsr%0d: got %h want %h", k, bus.lfsr_state, e.d); end
        end
        bus.seed_valid = 1'b0; bus.rdy = 2'b01;
        @(negedge clk);
        n_checks++; if (bus.vld !== 2'b00) begin n_fail++; $display("FAIL bp_release_vld: got %b want 00", bus.vld); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL bp_release_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.lfsr_state !== e.d) begin n_fail++; $display("FAIL bp_no_seed: got %h want %h", bus.lfsr_state, e.d); end
        bus.rdy = 2'b00;
    endtask

    task automatic test_mid_reset();
        int cyc; bit to; bit both;
        do_reset();
        bus.req = 2'b01; bus.rdy = 2'b01;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL step_busy: got %b want 1", bus.busy); end
        n_checks++; if (bus.lfsr_state !== 8'h40) begin n_fail++; $display("FAIL step_lfsr: got %h want 40", bus.lfsr_state); end
        rst = 1'b1; bus.req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (bus.vld !== 2'b00) begin n_fail++; $display("FAIL mrst_vld: got %b want 00", bus.vld); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy: got %b want 0", bus.busy); end
        n_checks++; if (bus.lfsr_state !== 8'h01) begin n_fail++; $display("FAIL mrst_lfsr: got %h want 01", bus.lfsr_state); end
        // Reset while holding data in DELIVER.
        bus.req = 2'b01; bus.rdy = 2'b00;
        wait_vld(cyc, to, both);
        n_checks++; if (to) begin n_fail++; $display("FAIL drst_wait: timeout=%0b want 0", to); end
        rst = 1'b1; bus.req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (bus.vld !== 2'b00) begin n_fail++; $display("FAIL drst_vld: got %b want 00", bus.vld); end
        n_checks++; if (bus.data !== 8'h00) begin n_fail++; $display("FAIL drst_data: got %h want 00", bus.data); end
    endtask

`ifdef PRNG_FREERUN_EN
    task automatic test_freerun();
        int cyc; bit to; bit both; exp_t e;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        // Two idle shifts, one more on the grant edge, then eight steps.
        bus.req = 2'b01; bus.rdy = 2'b01;
        predict(0, 11);
        wait_vld(cyc, to, both);
        pop_exp(e);
        n_checks++; if (to || cyc != 9) begin n_fail++; $display("FAIL fr_latency: got %0d want 9 (timeout=%0b)", cyc, to); end
        n_checks++; if (bus.data !== e.d) begin n_fail++; $display("FAIL fr_data: got %h want %h", bus.data, e.d); end
        bus.req = 2'b00;
        @(negedge clk);
        bus.rdy = 2'b00;
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.seed_valid = 1'b0;  bus.seed = 8'h00;  bus.req = 2'b00;  bus.rdy = 2'b00;
        bus1.seed_valid = 1'b0; bus1.seed = 8'h00; bus1.req = 2'b00; bus1.rdy = 2'b00;
        model = 8'h01;
        test_reset();
`ifdef PRNG_FREERUN_EN
        test_freerun();
`else
        test_first_grant();
        test_round_robin();
        test_seed();
        test_backpressure();
        test_mid_reset();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
